mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the single shared instruction/data memory of the multicycle MIPS. The CPU datapath (driven by the control unit's fetch and load/store states) and a boot/debug loader each issue word requests; the block grants one requester at a time, drives the memory port for a parameterised number of wait cycles, returns read data with a one-cycle acknowledge, and raises a stall to the control unit while a CPU access is pending.

## Interface
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- LAT, 2, memory access latency in cycles, legal range 1..15; LAT=0 is illegal (elaboration error)
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write enable (1 = store)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_gnt  out  1  CPU owns memory port
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DW  read data, valid while cpu_ack=1
- cpu_stall  out  1  cpu_req & ~cpu_ack; gates control-unit state advance
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/AW/DW  loader request, same rules as CPU
- ldr_gnt, ldr_ack, ldr_rdata  out  1/1/DW  loader grant/ack/data, same rules as CPU
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable, valid with mem_en
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: if any req high, pick winner, latch its we/addr/wdata into mem_we/mem_addr/mem_wdata, set owner, cnt <= LAT, go BUSY. No req: stay IDLE.
- Arbitration: single req wins. Both high: round-robin, winner = requester not granted last; last_grant updates on each grant. After reset last_grant = CPU, so loader wins the first tie.
- BUSY: mem_en = 1 only in first BUSY cycle (cnt == LAT); cnt decrements each cycle. In cycle where cnt == 1, mem_rdata is sampled into owner's rdata register at end of cycle; go DONE.
- DONE: owner's ack = 1 for exactly this cycle; go IDLE. No new grant in DONE, so a requester still holding req during its ack cycle is not re-granted.
- Writes use the same sequence and latency; rdata register on writes holds mem_rdata sampled as for reads (don't-care to requester).
- gnt for owner high throughout BUSY and DONE; both gnt low in IDLE. Never both high.
- Request fields sampled only in IDLE grant cycle; changes after grant are ignored.
- cpu_stall combinational from cpu_req and cpu_ack; everything else registered.

## Timing
- Reset values: cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_en, mem_we = 0; mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0; cnt = 0; last_grant = CPU.
- Request seen high at edge ending cycle T (IDLE): mem_en in T+1, data sampled end of T+LAT, ack in T+LAT+1, IDLE again at T+LAT+2.
- Request-to-ack latency LAT+1 cycles; max throughput one access per LAT+2 cycles.
- Requester must drop req (or present new request) at the edge ending its ack cycle; a req still high in the following IDLE cycle is a new request.
- Losing requester waits; with both continuously requesting, grants alternate, worst-case wait = one full access (LAT+2 cycles).
- Reset asserted mid-BUSY/DONE: next cycle IDLE, all outputs at reset values, no ack issued for the aborted access.

## Test plan
- LAT=2, CPU read alone, addr 0x0000_0010, mem returns 0xDEAD_BEEF: mem_en cycle 1, cpu_ack cycle 3 with cpu_rdata=0xDEAD_BEEF, cpu_stall high cycles 0–2.
- Loader write addr 0x0000_0040 data 0x1234_5678: single mem_en with mem_we=1, matching addr/data, ldr_ack after 3 cycles, cpu signals untouched.
- Both req asserted first cycle after reset and held: grant order loader, CPU, loader, CPU; grants never overlap; acks 4 cycles apart.
- CPU changes cpu_addr to 0x0000_0080 during BUSY: mem_addr stays at granted address; no second mem_en.
- reset asserted in first BUSY cycle: next cycle gnt/ack/mem_en all 0, no ack ever issued; subsequent request completes normally.
- LAT=1 build: request to ack 2 cycles, back-to-back CPU requests complete every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer giving the CPU and the boot loader
// turns on the shared MIPS memory, with a fixed wait of LAT cycles per access.
module mem_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_ack,
   output logic [DW-1:0] ldr_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   if (LAT < 1 || LAT > 15) begin : g_lat_chk
      $error("mem_arbiter: LAT must be in 1..15");
   end
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [3:0] LAT_C = 4'(LAT);
   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d, last_q, last_d;
   logic          en_q, en_d, we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d, crd_q, crd_d, lrd_q, lrd_d;
   logic          cack_q, cack_d, lack_q, lack_d, cgnt_q, cgnt_d, lgnt_q, lgnt_d;
   logic          win_ldr, sample;
   // owner_q/last_q: 1 = loader; on a tie the requester not granted last wins
   assign win_ldr = ldr_req & (~cpu_req | ~last_q);
   assign sample  = (state_q == BUSY) && (cnt_q == 4'd1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      en_d    = 1'b0;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cgnt_d  = cgnt_q;
      lgnt_d  = lgnt_q;
      cack_d  = 1'b0;
      lack_d  = 1'b0;
      crd_d   = (sample && !owner_q) ? mem_rdata : crd_q;
      lrd_d   = (sample && owner_q) ? mem_rdata : lrd_q;
      case (state_q)
         IDLE: if (cpu_req || ldr_req) begin
            state_d = BUSY;
            cnt_d   = LAT_C;
            owner_d = win_ldr;
            last_d  = win_ldr;
            en_d    = 1'b1;
            we_d    = win_ldr ? ldr_we : cpu_we;
            addr_d  = win_ldr ? ldr_addr : cpu_addr;
            wdata_d = win_ldr ? ldr_wdata : cpu_wdata;
            cgnt_d  = ~win_ldr;
            lgnt_d  = win_ldr;
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (sample) begin
               state_d = DONE;
               cack_d  = ~owner_q;
               lack_d  = owner_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            cgnt_d  = 1'b0;
            lgnt_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         crd_q   <= '0;
         lrd_q   <= '0;
         cack_q  <= 1'b0;
         lack_q  <= 1'b0;
         cgnt_q  <= 1'b0;
         lgnt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         crd_q   <= crd_d;
         lrd_q   <= lrd_d;
         cack_q  <= cack_d;
         lack_q  <= lack_d;
         cgnt_q  <= cgnt_d;
         lgnt_q  <= lgnt_d;
      end
   end
   assign cpu_gnt   = cgnt_q;
   assign cpu_ack   = cack_q;
   assign cpu_rdata = crd_q;
   assign cpu_stall = cpu_req & ~cack_q;
   assign ldr_gnt   = lgnt_q;
   assign ldr_ack   = lack_q;
   assign ldr_rdata = lrd_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus corner-case sequences for
// mem_arbiter at LAT=2, and a LAT=1 instance for back-to-back throughput.
module tb_mem_arbiter;
   typedef struct packed {
      logic cr, cw; logic [31:0] cad, cwd;
      logic lr, lw; logic [31:0] lad, lwd, mrd;
   } in_t;
   typedef struct packed {
      logic cg, ca; logic [31:0] crd;
      logic lg, la; logic [31:0] lrd;
      logic me, mw; logic [31:0] ma, mwd;
      logic st;
   } out_t;
   typedef struct { in_t i; out_t o; } vec_t;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] A5 = 32'hA5A5_A5A5;
   localparam logic [31:0] LW = 32'h1234_5678;
   logic clk = 1'b0, reset = 1'b1;
   logic cpu_req, cpu_we, ldr_req, ldr_we;
   logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;
   logic cpu_gnt, cpu_ack, cpu_stall, ldr_gnt, ldr_ack, mem_en, mem_we;
   logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
   logic u1_req, u1_gnt, u1_ack, u1_stall, u1_lgnt, u1_lack, u1_en, u1_we;
   logic [31:0] u1_rdata, u1_lrdata, u1_addr, u1_wdata, u1_mrd;
   out_t act;
   vec_t tv [9];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   mem_arbiter #(.AW(32), .DW(32), .LAT(2)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );
   mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u1 (
      .clk(clk), .reset(reset),
      .cpu_req(u1_req), .cpu_we(1'b0), .cpu_addr(32'h0000_0300), .cpu_wdata(32'h0),
      .cpu_gnt(u1_gnt), .cpu_ack(u1_ack), .cpu_rdata(u1_rdata), .cpu_stall(u1_stall),
      .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
      .ldr_gnt(u1_lgnt), .ldr_ack(u1_lack), .ldr_rdata(u1_lrdata),
      .mem_en(u1_en), .mem_we(u1_we), .mem_addr(u1_addr), .mem_wdata(u1_wdata),
      .mem_rdata(u1_mrd)
   );
   assign act = {cpu_gnt, cpu_ack, cpu_rdata, ldr_gnt, ldr_ack, ldr_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, cpu_stall};
   task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   task automatic drive(input in_t v);
      {cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata} = v;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      drive('0);
      u1_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask
   initial begin
      tv[0] = '{i: '{1, 0, 32'h10, 0, 0, 0, 0, 0, DB}, o: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
      tv[1] = '{i: '{1, 0, 32'h80, 0, 0, 0, 0, 0, DB}, o: '{1, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 1}};
      tv[2] = '{i: '{1, 0, 32'h80, 0, 0, 0, 0, 0, DB}, o: '{1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 1}};
      tv[3] = '{i: '{1, 0, 32'h80, 0, 0, 0, 0, 0, DB}, o: '{1, 1, DB, 0, 0, 0, 0, 0, 32'h10, 0, 0}};
      tv[4] = '{i: '{0, 0, 0, 0, 1, 1, 32'h40, LW, A5}, o: '{0, 0, DB, 0, 0, 0, 0, 0, 32'h10, 0, 0}};
      tv[5] = '{i: '{0, 0, 0, 0, 1, 1, 32'h40, LW, A5}, o: '{0, 0, DB, 1, 0, 0, 1, 1, 32'h40, LW, 0}};
      tv[6] = '{i: '{0, 0, 0, 0, 1, 1, 32'h40, LW, A5}, o: '{0, 0, DB, 1, 0, 0, 0, 1, 32'h40, LW, 0}};
      tv[7] = '{i: '{0, 0, 0, 0, 1, 1, 32'h40, LW, A5}, o: '{0, 0, DB, 1, 1, A5, 0, 1, 32'h40, LW, 0}};
      tv[8] = '{i: '{0, 0, 0, 0, 0, 0, 0, 0, A5}, o: '{0, 0, DB, 0, 0, A5, 0, 1, 32'h40, LW, 0}};
      u1_mrd = 32'hCAFE_0001;
      do_reset();
      // CPU read with address change during BUSY, then loader write
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         drive(tv[k].i);
         #1 chk($sformatf("vec%0d", k), 160'(act), 160'(tv[k].o));
      end
      // both requesters held: loader wins first tie, then strict alternation
      do_reset();
      for (int c = 0; c < 16; c++) begin
         logic lg, cg, la, ca;
         @(negedge clk);
         drive('{1, 0, 32'h20, 0, 1, 0, 32'h60, 0, 0});
         lg = (c >= 1 && c <= 3) || (c >= 9 && c <= 11);
         cg = (c >= 5 && c <= 7) || (c >= 13 && c <= 15);
         la = (c == 3 || c == 11);
         ca = (c == 7 || c == 15);
         #1 chk($sformatf("rr_c%0d", c), 160'({cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, cpu_stall}),
                160'({cg, lg, ca, la, ~ca}));
      end
      // reset during the first BUSY cycle aborts the access without an ack
      do_reset();
      for (int c = 0; c < 11; c++) begin
         logic cg, ca, me;
         logic [31:0] ma, rd;
         @(negedge clk);
         reset = (c == 1);
         drive('{(c <= 1 || c >= 7), 0, (c >= 7 ? 32'h200 : 32'h100), 0, 0, 0, 0, 0, 32'h0BAD_F00D});
         cg = (c == 1) || (c >= 8);
         me = (c == 1) || (c == 8);
         ca = (c == 10);
         ma = (c == 1) ? 32'h100 : (c >= 8 ? 32'h200 : 32'h0);
         rd = ca ? 32'h0BAD_F00D : 32'h0;
         #1 chk($sformatf("rst_c%0d", c),
                160'({cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_en, mem_addr, cpu_rdata}),
                160'({cg, 1'b0, ca, 1'b0, me, ma, rd}));
      end
      // LAT=1: request to ack in 2 cycles, one access every 3 cycles
      do_reset();
      for (int c = 0; c < 9; c++) begin
         logic cg, ca, me;
         @(negedge clk);
         u1_req = 1'b1;
         cg = (c % 3 != 0);
         me = (c % 3 == 1);
         ca = (c % 3 == 2);
         #1 chk($sformatf("lat1_c%0d", c), 160'({u1_gnt, u1_ack, u1_en, u1_rdata}),
                160'({cg, ca, me, (c >= 2 ? 32'hCAFE_0001 : 32'h0)}));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
